// File: rtl/bus_w_sink_pkg.sv
// -----------------------------------------------------------------------------
// bus_w_sink_pkg
// Shared definitions for the W bus sink: destination codes, the R0 byte-b
// mask, the two-state write FSM encoding and a byte-lane mask helper.
// Bit numbering note: the W bus numbers bit 0 as the MSB. In this RTL vectors
// are declared [15:0], so W byte b (bus bits 0:7) is [15:8] and W byte a
// (bus bits 8:15) is [7:0].
// -----------------------------------------------------------------------------
package bus_w_sink_pkg;

  localparam int          NREGS_DEF       = 8;
  localparam logic [15:0] R0_LOW_MASK_DEF = 16'hFF00;

  typedef enum logic [2:0] {
    DST_IR   = 3'd0,
    DST_KI   = 3'd1,
    DST_AT   = 3'd2,
    DST_AC   = 3'd3,
    DST_AR   = 3'd4,
    DST_IC   = 3'd5,
    DST_RN   = 3'd6,
    DST_SWAP = 3'd7
  } dst_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } state_e;

  // Bit mask of the lanes a write touches; inhibit inputs are active high.
  function automatic logic [15:0] lane_mask(input logic bwb, input logic bwa);
    lane_mask = {{8{~bwb}}, {8{~bwa}}};
  endfunction

endpackage

// File: rtl/bus_w_sink_bw_byte_reg.sv
// -----------------------------------------------------------------------------
// bw_byte_reg
// One 16-bit register with independent byte-b / byte-a load enables and an
// increment enable. Any byte write takes priority over the increment: written
// bytes take d, unwritten bytes hold their current (pre-increment) value.
// Ports:
//   clk   in   clock
//   clr   in   asynchronous active-high clear
//   we_b  in   load byte b (bits [15:8]) from d
//   we_a  in   load byte a (bits [7:0]) from d
//   inc   in   increment modulo 2^16 when no byte is written
//   d     in   load data
//   q     out  register contents
// -----------------------------------------------------------------------------
module bw_byte_reg (
  input  logic        clk,
  input  logic        clr,
  input  logic        we_b,
  input  logic        we_a,
  input  logic        inc,
  input  logic [15:0] d,
  output logic [15:0] q
);

  logic [15:0] r_q;
  logic [15:0] w_next;

  // Next value: byte loads beat the increment, no carry merging.
  always_comb begin
    w_next = r_q;
    if (we_b || we_a) begin
      if (we_b) begin
        w_next[15:8] = d[15:8];
      end else begin
        w_next[15:8] = r_q[15:8];
      end
      if (we_a) begin
        w_next[7:0] = d[7:0];
      end else begin
        w_next[7:0] = r_q[7:0];
      end
    end else if (inc) begin
      w_next = r_q + 16'd1;
    end else begin
      w_next = r_q;
    end
  end

  // Register with asynchronous clear.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_q <= 16'h0000;
    end else begin
      r_q <= w_next;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/bus_w_sink.sv
// -----------------------------------------------------------------------------
// bus_w_sink
// Destination side of the internal W bus. A request stages the W word and
// its routing, the following cycle commits the selected bytes into IR, KI,
// AT, AC, AR, IC or R0..R7 and pulses ack. AR and IC carry free-running
// increment inputs; R0's non-mask bits are flags loaded only via flag_we.
// Ports:
//   clk_sys, clr           clock, asynchronous active-high reset
//   w, req, dst, rn        W word, write request, destination, Rn index
//   bwb, bwa               byte b / byte a write inhibits
//   ar_inc, ic_inc         AR / IC increment
//   flag_we, flags         R0 flag write
//   ack, busy              commit pulse, staged-write indicator
//   ir, ki, at, ac, ar, ic register contents
//   r                      general registers, R0 in r[15:0]
// -----------------------------------------------------------------------------
module bus_w_sink
  import bus_w_sink_pkg::*;
#(
  parameter int          NREGS       = NREGS_DEF,
  parameter logic [15:0] R0_LOW_MASK = R0_LOW_MASK_DEF
) (
  input  logic                clk_sys,
  input  logic                clr,
  input  logic [15:0]         w,
  input  logic                req,
  output logic                ack,
  input  logic [2:0]          dst,
  input  logic [2:0]          rn,
  input  logic                bwb,
  input  logic                bwa,
  input  logic                ar_inc,
  input  logic                ic_inc,
  input  logic                flag_we,
  input  logic [15:0]         flags,
  output logic [15:0]         ir,
  output logic [15:0]         ki,
  output logic [15:0]         at,
  output logic [15:0]         ac,
  output logic [15:0]         ar,
  output logic [15:0]         ic,
  output logic [16*NREGS-1:0] r,
  output logic                busy
);

  state_e      r_state;
  state_e      w_state_next;
  logic [15:0] r_stg_w;
  dst_e        r_stg_dst;
  logic [2:0]  r_stg_rn;
  logic        r_stg_bwb;
  logic        r_stg_bwa;
  logic        r_ack;
  logic        r_busy;

  // Special registers indexed by their destination code 0..5.
  logic [5:0]  w_sp_we_b;
  logic [5:0]  w_sp_we_a;
  logic [5:0]  w_sp_inc;
  logic [15:0] w_sp_d [6];
  logic [15:0] w_sp_q [6];

  logic [NREGS-1:0] w_rn_we_b;
  logic [NREGS-1:0] w_rn_we_a;
  logic [15:0]      w_rn_q [NREGS];

  logic [15:0] w_r0_wmask;
  logic [15:0] w_r0_fmask;
  logic [15:0] w_r0_d;
  logic        w_r0_we;
  logic        w_commit;

  // Next-state logic: capture on req in IDLE, always return from COMMIT.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_state_next = ST_COMMIT;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_COMMIT: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // State, staging register and registered ack/busy.
  always_ff @(posedge clk_sys or posedge clr) begin
    if (clr) begin
      r_state   <= ST_IDLE;
      r_stg_w   <= 16'h0000;
      r_stg_dst <= DST_IR;
      r_stg_rn  <= 3'd0;
      r_stg_bwb <= 1'b1;
      r_stg_bwa <= 1'b1;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ack   <= (w_state_next == ST_COMMIT);
      r_busy  <= (w_state_next == ST_COMMIT);
      if (r_state == ST_IDLE && req) begin
        r_stg_w   <= w;
        r_stg_dst <= dst_e'(dst);
        r_stg_rn  <= rn;
        r_stg_bwb <= bwb;
        r_stg_bwa <= bwa;
      end else begin
        r_stg_w   <= r_stg_w;
        r_stg_dst <= r_stg_dst;
        r_stg_rn  <= r_stg_rn;
        r_stg_bwb <= r_stg_bwb;
        r_stg_bwa <= r_stg_bwa;
      end
    end
  end

  assign w_commit = (r_state == ST_COMMIT);

  // Commit decode: per-register byte enables and load data.
  always_comb begin
    w_sp_we_b = 6'b000000;
    w_sp_we_a = 6'b000000;
    w_rn_we_b = '0;
    w_rn_we_a = '0;
    for (int i = 0; i < 6; i++) begin
      w_sp_d[i] = r_stg_w;
    end
    w_sp_inc = {ic_inc, ar_inc, 4'b0000};
    if (w_commit) begin
      case (r_stg_dst)
        DST_IR, DST_KI, DST_AT, DST_AC, DST_AR, DST_IC: begin
          w_sp_we_b[r_stg_dst] = ~r_stg_bwb;
          w_sp_we_a[r_stg_dst] = ~r_stg_bwa;
        end
        DST_RN: begin
          for (int i = 0; i < NREGS; i++) begin
            if (r_stg_rn == i[2:0]) begin
              w_rn_we_b[i] = ~r_stg_bwb;
              w_rn_we_a[i] = ~r_stg_bwa;
            end else begin
              w_rn_we_b[i] = 1'b0;
              w_rn_we_a[i] = 1'b0;
            end
          end
        end
        DST_SWAP: begin
          // Byte a of W lands in byte b of AC, gated by bwa only.
          w_sp_we_b[DST_AC] = ~r_stg_bwa;
          w_sp_we_a[DST_AC] = 1'b0;
          w_sp_d[DST_AC]    = {r_stg_w[7:0], r_stg_w[7:0]};
        end
        default: begin
          w_sp_we_b = 6'b000000;
          w_sp_we_a = 6'b000000;
        end
      endcase
    end else begin
      w_sp_we_b = 6'b000000;
      w_sp_we_a = 6'b000000;
    end
  end

  // R0 merge: W writes only mask bits, flag_we only non-mask bits; disjoint.
  always_comb begin
    w_r0_wmask = 16'h0000;
    w_r0_fmask = 16'h0000;
    if (w_commit && r_stg_dst == DST_RN && r_stg_rn == 3'd0) begin
      w_r0_wmask = lane_mask(r_stg_bwb, r_stg_bwa) & R0_LOW_MASK;
    end else begin
      w_r0_wmask = 16'h0000;
    end
    if (flag_we) begin
      w_r0_fmask = ~R0_LOW_MASK;
    end else begin
      w_r0_fmask = 16'h0000;
    end
    w_r0_d  = (w_rn_q[0] & ~(w_r0_wmask | w_r0_fmask))
            | (r_stg_w & w_r0_wmask)
            | (flags & w_r0_fmask);
    w_r0_we = |(w_r0_wmask | w_r0_fmask);
  end

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_sp
      bw_byte_reg u_reg (
        .clk  (clk_sys),
        .clr  (clr),
        .we_b (w_sp_we_b[gi]),
        .we_a (w_sp_we_a[gi]),
        .inc  (w_sp_inc[gi]),
        .d    (w_sp_d[gi]),
        .q    (w_sp_q[gi])
      );
    end

    for (gi = 0; gi < NREGS; gi++) begin : g_rn
      if (gi == 0) begin : g_r0
        bw_byte_reg u_reg (
          .clk  (clk_sys),
          .clr  (clr),
          .we_b (w_r0_we),
          .we_a (w_r0_we),
          .inc  (1'b0),
          .d    (w_r0_d),
          .q    (w_rn_q[gi])
        );
      end else begin : g_rx
        bw_byte_reg u_reg (
          .clk  (clk_sys),
          .clr  (clr),
          .we_b (w_rn_we_b[gi]),
          .we_a (w_rn_we_a[gi]),
          .inc  (1'b0),
          .d    (r_stg_w),
          .q    (w_rn_q[gi])
        );
      end
      assign r[16*gi +: 16] = w_rn_q[gi];
    end
  endgenerate

  assign ir   = w_sp_q[0];
  assign ki   = w_sp_q[1];
  assign at   = w_sp_q[2];
  assign ac   = w_sp_q[3];
  assign ar   = w_sp_q[4];
  assign ic   = w_sp_q[5];
  assign ack  = r_ack;
  assign busy = r_busy;

endmodule

// File: tb/tb_bus_w_sink.sv
// -----------------------------------------------------------------------------
// tb_bus_w_sink
// Directed bench for bus_w_sink. Inputs change and outputs are sampled on the
// falling edge of clk_sys; expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_bus_w_sink;

  logic         clk_sys = 1'b0;
  logic         clr     = 1'b1;
  logic [15:0]  w       = 16'h0000;
  logic         req     = 1'b0;
  logic         ack;
  logic [2:0]   dst     = 3'd0;
  logic [2:0]   rn      = 3'd0;
  logic         bwb     = 1'b0;
  logic         bwa     = 1'b0;
  logic         ar_inc  = 1'b0;
  logic         ic_inc  = 1'b0;
  logic         flag_we = 1'b0;
  logic [15:0]  flags   = 16'h0000;
  logic [15:0]  ir, ki, at, ac, ar, ic;
  logic [127:0] r;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;
  int ack_cnt;

  always #5 clk_sys = ~clk_sys;

  bus_w_sink dut (
    .clk_sys (clk_sys),
    .clr     (clr),
    .w       (w),
    .req     (req),
    .ack     (ack),
    .dst     (dst),
    .rn      (rn),
    .bwb     (bwb),
    .bwa     (bwa),
    .ar_inc  (ar_inc),
    .ic_inc  (ic_inc),
    .flag_we (flag_we),
    .flags   (flags),
    .ir      (ir),
    .ki      (ki),
    .at      (at),
    .ac      (ac),
    .ar      (ar),
    .ic      (ic),
    .r       (r),
    .busy    (busy)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rsel(input logic [127:0] rv, input int idx);
    rsel = rv[16*idx +: 16];
  endfunction

  // One request/commit; side inputs apply during the commit cycle only.
  // Starts and ends on a falling edge.
  task automatic do_write(input logic [2:0] d, input logic [2:0] n, input logic [15:0] wd,
                          input logic b_inh, input logic a_inh,
                          input logic c_ar, input logic c_ic,
                          input logic c_fw, input logic [15:0] c_fl);
    req = 1'b1; dst = d; rn = n; w = wd; bwb = b_inh; bwa = a_inh;
    @(posedge clk_sys); @(negedge clk_sys);
    req = 1'b0;
    chk("ack_commit_cycle", {15'd0, ack}, 16'd1);
    chk("busy_commit_cycle", {15'd0, busy}, 16'd1);
    ar_inc = c_ar; ic_inc = c_ic; flag_we = c_fw; flags = c_fl;
    @(posedge clk_sys); @(negedge clk_sys);
    ar_inc = 1'b0; ic_inc = 1'b0; flag_we = 1'b0; flags = 16'h0000;
    chk("ack_after_commit", {15'd0, ack}, 16'd0);
    chk("busy_after_commit", {15'd0, busy}, 16'd0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_ir", ir, 16'h0000);
    chk("rst_ac", ac, 16'h0000);
    chk("rst_ar", ar, 16'h0000);
    chk("rst_ic", ic, 16'h0000);
    chk("rst_r0", rsel(r, 0), 16'h0000);
    chk("rst_ack", {15'd0, ack}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    @(negedge clk_sys);
    clr = 1'b0;
    @(negedge clk_sys);

    // Byte lanes: only byte b written, not visible until commit edge
    req = 1'b1; dst = 3'd3; w = 16'hABCD; bwb = 1'b0; bwa = 1'b1;
    @(posedge clk_sys); @(negedge clk_sys);
    req = 1'b0;
    chk("lane_ack_n1", {15'd0, ack}, 16'd1);
    chk("lane_busy_n1", {15'd0, busy}, 16'd1);
    chk("lane_ac_not_yet", ac, 16'h0000);
    @(posedge clk_sys); @(negedge clk_sys);
    chk("lane_ac", ac, 16'hAB00);
    chk("lane_ack_n2", {15'd0, ack}, 16'd0);
    chk("lane_busy_n2", {15'd0, busy}, 16'd0);

    do_write(3'd0, 3'd0, 16'hCAFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("ir_full", ir, 16'hCAFE);
    do_write(3'd1, 3'd0, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("ki_byte_a", ki, 16'h00EF);
    do_write(3'd2, 3'd0, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("at_both_inhibited", at, 16'h0000);

    // SWAP into AC
    do_write(3'd3, 3'd0, 16'h1122, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("ac_1122", ac, 16'h1122);
    do_write(3'd7, 3'd0, 16'h00EE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("swap_ac", ac, 16'hEE22);
    do_write(3'd7, 3'd0, 16'h0099, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("swap_inhibited", ac, 16'hEE22);

    // AR wrap and commit/increment conflict
    do_write(3'd4, 3'd0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("ar_ffff", ar, 16'hFFFF);
    ar_inc = 1'b1;
    @(posedge clk_sys); @(negedge clk_sys);
    ar_inc = 1'b0;
    chk("ar_wrap", ar, 16'h0000);
    do_write(3'd4, 3'd0, 16'h5678, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("ar_conflict", ar, 16'h0078);

    // IC increment with carry across bytes
    do_write(3'd5, 3'd0, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    ic_inc = 1'b1;
    @(posedge clk_sys); @(negedge clk_sys);
    ic_inc = 1'b0;
    chk("ic_carry", ic, 16'h0100);

    // R0 masking with concurrent flag write
    do_write(3'd6, 3'd0, 16'hABCD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00FF);
    chk("r0_merge", rsel(r, 0), 16'hABFF);
    flag_we = 1'b1; flags = 16'hFF00;
    @(posedge clk_sys); @(negedge clk_sys);
    flag_we = 1'b0; flags = 16'h0000;
    chk("r0_flags_clear", rsel(r, 0), 16'hAB00);
    do_write(3'd6, 3'd0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("r0_w_only", rsel(r, 0), 16'h1200);

    // Back-to-back: req held four cycles -> two commits
    ack_cnt = 0;
    req = 1'b1; dst = 3'd6; rn = 3'd5; w = 16'h0001; bwb = 1'b0; bwa = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_sys); @(negedge clk_sys);
      if (ack) ack_cnt++;
    end
    req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_sys); @(negedge clk_sys);
      if (ack) ack_cnt++;
    end
    chk("b2b_ack_count", ack_cnt[15:0], 16'd2);
    chk("b2b_r5", rsel(r, 5), 16'h0001);
    chk("b2b_r4_untouched", rsel(r, 4), 16'h0000);

    // Reset in the middle of a commit
    req = 1'b1; dst = 3'd3; w = 16'h1234; bwb = 1'b0; bwa = 1'b0;
    @(posedge clk_sys); @(negedge clk_sys);
    req = 1'b0;
    chk("rst_mid_ack_before", {15'd0, ack}, 16'd1);
    #2 clr = 1'b1;
    #1;
    chk("rst_mid_busy", {15'd0, busy}, 16'd0);
    chk("rst_mid_ack", {15'd0, ack}, 16'd0);
    chk("rst_mid_ac", ac, 16'h0000);
    chk("rst_mid_ir", ir, 16'h0000);
    @(negedge clk_sys);
    clr = 1'b0;
    ack_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_sys); @(negedge clk_sys);
      if (ack) ack_cnt++;
    end
    chk("rst_mid_no_ack", ack_cnt[15:0], 16'd0);
    chk("rst_mid_ac_after", ac, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
